// File: rtl/mem_pkg.sv
// Shared constants for the data-memory path: access-unit state encoding and
// RAM pin conventions, reused by the ROM/RAM models.
package mem_pkg;

   localparam int unsigned MEM_DATA_W = 16;
   localparam int unsigned MEM_DEPTH  = 512;

   // RAM rw pin polarity
   localparam logic MEM_READ  = 1'b1;
   localparam logic MEM_WRITE = 1'b0;

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StIssue = 2'd1;
   localparam logic [1:0] StWait  = 2'd2;
   localparam logic [1:0] StResp  = 2'd3;

endpackage

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store initiator for the 16-bit data RAM port.
// Optional address range check enabled by MEM_ACCESS_BOUNDS_CHECK_EN.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int unsigned DEPTH    = MEM_DEPTH,
   parameter int unsigned READ_LAT = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [MEM_DATA_W-1:0] req_addr,
   input  logic [MEM_DATA_W-1:0] req_wdata,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [MEM_DATA_W-1:0] resp_rdata,
   output logic                  resp_err,
   output logic                  mem_en,
   output logic                  mem_rw,
   output logic [MEM_DATA_W-1:0] mem_addr,
   output logic [MEM_DATA_W-1:0] mem_a,
   input  logic [MEM_DATA_W-1:0] mem_q
);

   if (READ_LAT < 1 || READ_LAT > 7) begin : g_bad_read_lat
      $error("mem_access_unit: READ_LAT must be in 1..7");
   end
   if (DEPTH < 1 || DEPTH > 65536) begin : g_bad_depth
      $error("mem_access_unit: DEPTH must be in 1..65536");
   end

   logic [1:0]            state_q, state_d;
   logic                  we_q, we_d;
   logic [2:0]            cnt_q, cnt_d;
   logic                  mem_en_q, mem_en_d;
   logic                  mem_rw_q, mem_rw_d;
   logic [MEM_DATA_W-1:0] mem_addr_q, mem_addr_d;
   logic [MEM_DATA_W-1:0] mem_a_q, mem_a_d;
   logic                  resp_valid_q, resp_valid_d;
   logic [MEM_DATA_W-1:0] resp_rdata_q, resp_rdata_d;
   logic                  oob;

`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
   logic resp_err_q, resp_err_d;
   assign oob      = 32'(req_addr) >= DEPTH;
   assign resp_err = resp_err_q;
`else
   assign oob      = 1'b0;
   assign resp_err = 1'b0;
`endif

   assign req_ready  = (state_q == StIdle) & ~rst;
   assign mem_en     = mem_en_q;
   assign mem_rw     = mem_rw_q;
   assign mem_addr   = mem_addr_q;
   assign mem_a      = mem_a_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;

   always_comb begin
      state_d      = state_q;
      we_d         = we_q;
      cnt_d        = cnt_q;
      mem_en_d     = 1'b0;
      mem_rw_d     = mem_rw_q;
      mem_addr_d   = mem_addr_q;
      mem_a_d      = mem_a_q;
      resp_valid_d = resp_valid_q;
      resp_rdata_d = resp_rdata_q;
`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
      resp_err_d   = resp_err_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               we_d         = req_we;
               mem_addr_d   = req_addr;
               mem_a_d      = req_wdata;
               resp_rdata_d = '0;
`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
               resp_err_d   = oob;
`endif
               if (oob) begin
                  // Out-of-range: answer directly, never touch the RAM
                  resp_valid_d = 1'b1;
                  state_d      = StResp;
               end else begin
                  mem_en_d = 1'b1;
                  mem_rw_d = req_we ? MEM_WRITE : MEM_READ;
                  state_d  = StIssue;
               end
            end
         end
         StIssue: begin
            // rw rests at read so an idle bus can never write
            mem_rw_d = MEM_READ;
            if (we_q) begin
               resp_valid_d = 1'b1;
               state_d      = StResp;
            end else begin
               cnt_d   = 3'(READ_LAT);
               state_d = StWait;
            end
         end
         StWait: begin
            if (cnt_q == 3'd1) begin
               resp_rdata_d = mem_q;
               resp_valid_d = 1'b1;
               state_d      = StResp;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         StResp: begin
            if (resp_ready) begin
               resp_valid_d = 1'b0;
               state_d      = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         we_q         <= 1'b0;
         cnt_q        <= '0;
         mem_en_q     <= 1'b0;
         mem_rw_q     <= MEM_READ;
         mem_addr_q   <= '0;
         mem_a_q      <= '0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
         resp_err_q   <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         we_q         <= we_d;
         cnt_q        <= cnt_d;
         mem_en_q     <= mem_en_d;
         mem_rw_q     <= mem_rw_d;
         mem_addr_q   <= mem_addr_d;
         mem_a_q      <= mem_a_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
         resp_err_q   <= resp_err_d;
`endif
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit against a transaction-level
// model (expected memory contents, latencies and accept spacing).
module tb_mem_access_unit;

   localparam int unsigned DEPTH    = 512;
   localparam int unsigned READ_LAT = 1;
`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
   localparam bit BOUNDS = 1'b1;
`else
   localparam bit BOUNDS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we;
   logic [15:0] req_addr, req_wdata;
   logic        resp_valid, resp_ready, resp_err;
   logic [15:0] resp_rdata;
   logic        mem_en, mem_rw;
   logic [15:0] mem_addr, mem_a, mem_q;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   bit [15:0] ram [0:65535];
   bit [15:0] ref_mem [int];
   logic [15:0] q_reg = '0;

   mem_access_unit #(
      .DEPTH    (DEPTH),
      .READ_LAT (READ_LAT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_en     (mem_en),
      .mem_rw     (mem_rw),
      .mem_addr   (mem_addr),
      .mem_a      (mem_a),
      .mem_q      (mem_q)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // RAM with a one-cycle registered read
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_rw == 1'b0) ram[mem_addr] = mem_a;
         else q_reg <= ram[mem_addr];
      end
   end
   assign mem_q = q_reg;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic bit [15:0] ref_read(input bit [15:0] a);
      return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 16'h0;
   endfunction

   task automatic do_txn(input bit we, input bit [15:0] addr, input bit [15:0] wdata,
                         input int stall);
      bit        exp_err;
      int        exp_lat, k, en_cnt;
      bit [15:0] exp_data, held;
      exp_err  = BOUNDS && (addr >= DEPTH);
      exp_lat  = exp_err ? 1 : (we ? 2 : 2 + int'(READ_LAT));
      exp_data = (we || exp_err) ? 16'h0 : ref_read(addr);
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      k = 0;
      while (!req_ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      check_val("hs_ready", {31'b0, req_ready}, 32'd1);
      @(negedge clk);
      req_valid = 1'b0;
      k = 1;
      en_cnt = 0;
      while (!resp_valid && k < 20) begin
         check_val("busy_req_ready", {31'b0, req_ready}, 32'd0);
         if (mem_en) begin
            en_cnt++;
            check_val("mem_rw", {31'b0, mem_rw}, {31'b0, ~we});
            check_val("mem_addr", {16'b0, mem_addr}, {16'b0, addr});
            check_val("mem_a", {16'b0, mem_a}, {16'b0, wdata});
         end
         @(negedge clk);
         k++;
      end
      check_val("resp_latency", k, exp_lat);
      check_val("mem_en_pulses", en_cnt, exp_err ? 0 : 1);
      check_val("resp_rdata", {16'b0, resp_rdata}, {16'b0, exp_data});
      check_val("resp_err", {31'b0, resp_err}, {31'b0, exp_err});
      held = resp_rdata;
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         check_val("stall_valid", {31'b0, resp_valid}, 32'd1);
         check_val("stall_rdata", {16'b0, resp_rdata}, {16'b0, held});
         check_val("stall_mem_en", {31'b0, mem_en}, 32'd0);
         check_val("stall_req_ready", {31'b0, req_ready}, 32'd0);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      check_val("resp_cleared", {31'b0, resp_valid}, 32'd0);
      check_val("idle_ready", {31'b0, req_ready}, 32'd1);
      if (we && !exp_err) ref_mem[int'(addr)] = wdata;
   endtask

   initial begin
      bit        bw [6];
      int        prev_cyc, n;
      bit        w;
      bit [15:0] a;

      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      resp_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_val("rst_req_ready", {31'b0, req_ready}, 32'd0);
      check_val("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
      check_val("rst_resp_rdata", {16'b0, resp_rdata}, 32'd0);
      check_val("rst_resp_err", {31'b0, resp_err}, 32'd0);
      check_val("rst_mem_en", {31'b0, mem_en}, 32'd0);
      check_val("rst_mem_rw", {31'b0, mem_rw}, 32'd1);
      check_val("rst_mem_addr", {16'b0, mem_addr}, 32'd0);
      check_val("rst_mem_a", {16'b0, mem_a}, 32'd0);
      rst = 1'b0;
      #1;
      check_val("post_rst_ready", {31'b0, req_ready}, 32'd1);

      // Directed: store, load-back, load under backpressure
      do_txn(1'b1, 16'h0010, 16'hBEEF, 0);
      do_txn(1'b0, 16'h0010, 16'h0000, 0);
      do_txn(1'b0, 16'h0010, 16'h0000, 5);

`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
      do_txn(1'b0, 16'h0200, 16'h0000, 0);
      do_txn(1'b0, 16'h01FF, 16'h0000, 0);
      do_txn(1'b1, 16'hFFFF, 16'h1234, 1);
      do_txn(1'b0, 16'hFFFF, 16'h0000, 0);
`endif

      // Randomized mix concentrated on a few addresses so loads hit stores
      for (int t = 0; t < 60; t++) begin
         w = 1'(($urandom & 1));
         a = 16'($urandom_range(0, 15));
         if (($urandom & 7) == 0) a = 16'($urandom_range(0, DEPTH - 1));
         if (BOUNDS && ($urandom & 7) == 1) a = 16'($urandom);
         do_txn(w, a, 16'($urandom), int'($urandom_range(0, 2)));
      end

      // Reset during the ISSUE cycle of a load
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0005;
      @(negedge clk);
      req_valid = 1'b0;
      check_val("rstmid_issue_en", {31'b0, mem_en}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check_val("rstmid_mem_en", {31'b0, mem_en}, 32'd0);
      check_val("rstmid_resp_valid", {31'b0, resp_valid}, 32'd0);
      check_val("rstmid_req_ready", {31'b0, req_ready}, 32'd0);
      rst = 1'b0;
      #1;
      check_val("rstmid_ready_after", {31'b0, req_ready}, 32'd1);
      resp_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check_val("rstmid_no_resp", {31'b0, resp_valid}, 32'd0);
      end

      // Back-to-back burst: req_valid held, resp_ready held
      bw[0] = 1; bw[1] = 0; bw[2] = 1; bw[3] = 1; bw[4] = 0; bw[5] = 0;
      prev_cyc = 0;
      @(negedge clk);
      req_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         req_we    = bw[i];
         req_addr  = 16'(32 + i);
         req_wdata = 16'($urandom);
         n = 0;
         while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
         end
         check_val("burst_ready", {31'b0, req_ready}, 32'd1);
         if (i > 0)
            check_val("burst_spacing", cyc - prev_cyc, bw[i-1] ? 3 : int'(READ_LAT) + 3);
         prev_cyc = cyc;
         if (bw[i]) ref_mem[32 + i] = req_wdata;
         @(negedge clk);
      end
      req_valid = 1'b0;
      repeat (6) @(negedge clk);
      resp_ready = 1'b0;

      // Burst stores must be visible to later loads
      do_txn(1'b0, 16'd32, 16'h0, 0);
      do_txn(1'b0, 16'd35, 16'h0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

- Bus-master (initiator) for the 16-bit data RAM port.
- Accepts one load/store request at a time from the processor core over a valid/ready handshake, then drives the RAM's `en`/`rw`/`addr`/`A` pins.
- For reads, waits the RAM's registered-read latency, captures `Q`, and returns the result over a valid/ready response channel.
- Sits between the core's load/store stage and the RAM instance.

## Interface
- `DEPTH`, 512: number of addressable RAM words; upper bound for the range check.
- `READ_LAT`, 1: cycles from the RAM capturing a read command to `mem_q` being stable; legal range 1–7.
- `clk`  in  1: single clock. The RAM is driven from this same clock.
- `rst`  in  1: reset, synchronous, active-high.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: unit can accept a request.
- `req_we`  in  1: 1 = store, 0 = load.
- `req_addr`  in  16: word address.
- `req_wdata`  in  16: store data.
- `resp_valid`  out  1: response present.
- `resp_ready`  in  1: core consumes the response.
- `resp_rdata`  out  16: load data; 0 for stores.
- `resp_err`  out  1: address out of range (see Configuration).
- `mem_en`  out  1: RAM enable.
- `mem_rw`  out  1: 1 = read, 0 = write (RAM convention).
- `mem_addr`  out  16: RAM address.
- `mem_a`  out  16: RAM write data.
- `mem_q`  in  16: RAM read data.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid & req_ready`, latch `req_we`/`req_addr`/`req_wdata` and go to ISSUE.
- **ISSUE** (exactly one cycle)
  - `mem_en`=1, `mem_rw`=~we, `mem_addr`=latched address, `mem_a`=latched data.
  - Store: go to RESP.
  - Load: load the wait counter with `READ_LAT` and go to WAIT.
- **WAIT**
  - `mem_en`=0.
  - The counter decrements each cycle.
  - In the cycle the counter reaches 1, register `mem_q` into `resp_rdata` and go to RESP.
- **RESP**
  - `resp_valid`=1; `resp_rdata`/`resp_err` are held stable.
  - On `resp_ready`, clear `resp_valid` and go to IDLE.
- `req_ready` is 0 in every state except IDLE. Only one transaction is outstanding.
- `mem_en` is 0 in every state except ISSUE. Between transactions `mem_rw` rests at 1 (read), so no stray write occurs.
- All outputs are registered, except `req_ready`, which is decoded from the state register.
- Address width rule: `mem_addr` = `req_addr` unmodified (16 bits). The range test is an unsigned compare `req_addr >= DEPTH`.

## Timing
- **Reset**
  - While `rst`=1 at a clock edge: state←IDLE.
  - Output values: `req_ready`=0 while `rst` is high; `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `mem_en`=0, `mem_rw`=1, `mem_addr`=0, `mem_a`=0.
  - `req_ready`=1 in the first cycle after `rst` falls.
- **Store latency.** Handshake in cycle N → `mem_en` in N+1 → `resp_valid` in N+2.
- **Load latency.** Handshake in N → ISSUE in N+1 → RAM captures at the end of N+1 → `mem_q` is sampled at the end of N+1+`READ_LAT` → `resp_valid` in N+2+`READ_LAT`. With the default, that is N+3.
- **Throughput.** With `resp_ready` tied 1, the minimum spacing between accepted requests is 3 cycles for stores and `READ_LAT`+3 cycles for loads.
- **Response consumed with a new request waiting.** If `resp_ready` and `req_valid` are both high in RESP, the request is not accepted in that cycle. It is accepted in the following IDLE cycle.
- **Backpressure.** `resp_ready` held low stalls the unit in RESP indefinitely. No RAM access occurs during the stall.
- **Reset mid-transaction.** The transaction is abandoned and no response is produced. `mem_en` is 0 from the cycle after the reset edge. A write already issued in ISSUE may have completed in the RAM.
- **Address wrap.** `req_addr`=16'hFFFF is compared, not wrapped. There is no address arithmetic.

## Configuration
- Macro: `MEM_ACCESS_BOUNDS_CHECK_EN`.
- **Defined:**
  - An accepted request with `req_addr >= DEPTH` skips ISSUE. `mem_en` is never pulsed.
  - The unit goes IDLE→RESP with `resp_err`=1 and `resp_rdata`=0; `resp_valid` rises at N+1.
  - In-range requests respond with `resp_err`=0.
- **Undefined:**
  - No compare logic is built and `resp_err` is a constant 0.
  - Out-of-range addresses are issued to the RAM as-is. The result is undefined (RAM-dependent).

## Structure
- Shared package `mem_pkg` holds:
  - the state encoding (IDLE, ISSUE, WAIT, RESP);
  - constants `MEM_READ`=1'b1 and `MEM_WRITE`=1'b0;
  - `MEM_DEPTH`=512 and `MEM_DATA_W`=16.
- The ROM and RAM models reuse `MEM_READ`, `MEM_WRITE`, `MEM_DEPTH` and `MEM_DATA_W`.
- The unit is a single module with no sub-modules. The `READ_LAT` counter (3 bits) is inline.

## Test plan
1. Reset, then store addr 16'h0010 data 16'hBEEF → `mem_en`=1, `mem_rw`=0, `mem_addr`=16'h0010, `mem_a`=16'hBEEF for one cycle; `resp_valid` 2 cycles after the handshake with `resp_rdata`=0.
2. Load addr 16'h0010 after test 1 (`READ_LAT`=1) → one read pulse; `resp_valid` 3 cycles after the handshake with `resp_rdata`=16'hBEEF.
3. Load with `resp_ready` held 0 for 5 cycles → `resp_valid` and `resp_rdata` stay stable; `req_ready`=0; no `mem_en` pulses.
4. With the macro defined, load addr 16'h0200 → no `mem_en`; `resp_valid` at N+1 with `resp_err`=1 and `resp_rdata`=0. Then load 16'h01FF → `resp_err`=0.
5. `rst`=1 in the ISSUE cycle of a load → from the next cycle `mem_en`=0, `resp_valid`=0 and no response ever appears; `req_ready`=1 after `rst` falls.
6. Run a store/load burst with `resp_ready`=1 and `req_valid` held high → accepts are spaced exactly 3 (store) and 4 (load) cycles apart.
